// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the fetch stage and pipecontrol: PC-select encodings,
// the NOP instruction word, the default reset PC, the IF/ID payload type and
// the branch-offset helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

  // PC source select driven by decode control (branch_mux).
  // The reserved value is treated as sequential.
  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_BRANCH = 2'd1,
    PCSEL_JUMP   = 2'd2,
    PCSEL_RSVD   = 2'd3
  } pcsel_e;

  // sll $0,$0,0 -- the all-zero word doubles as the pipeline bubble.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0000_0000, valid: 1'b0};

  // Word offset of a branch immediate: sign-extend bit 15, then scale by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump target: top nibble of PC+4 concatenated with the 26-bit word index.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc4, input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority per edge: async reset, stall (hold),
// flush (bubble), load.
// Ports:
//   clk, reset       : clock, async active-high reset
//   stall            : hold current contents
//   flush            : load a bubble (NOP, pc4 = 0, valid = 0)
//   instr_in, pc4_in : fetched instruction and its PC+4
//   instr, pc4, valid: registered outputs to decode
// -----------------------------------------------------------------------------
module if_id_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  if_id_t cur;
  if_id_t nxt;

  // Next-value selection: hold on stall, bubble on flush, else load.
  always_comb begin
    nxt = cur;
    if (stall) begin
      nxt = cur;
    end else if (flush) begin
      nxt = IF_ID_BUBBLE;
    end else begin
      nxt.instr = instr_in;
      nxt.pc4   = pc4_in;
      nxt.valid = 1'b1;
    end
  end

  // IF/ID state register with asynchronous clear to a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= IF_ID_BUBBLE;
    end else begin
      cur <= nxt;
    end
  end

  assign instr = cur.instr;
  assign pc4   = cur.pc4;
  assign valid = cur.valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC register, next-PC mux, branch/jump target
// computation from the IF/ID contents, and the IF/ID register instance.
// Parameters:
//   RESET_PC      : PC loaded on reset
// Ports:
//   clk, reset    : clock, async active-high reset
//   stall         : hazard-unit freeze of PC and IF/ID
//   branch_mux    : PC source (0 seq, 1 branch, 2 jump, 3 treated as seq)
//   if_flush      : load a bubble into IF/ID
//   imem_addr     : instruction memory address (= PC)
//   imem_data     : instruction at imem_addr (combinational read)
//   if_id_instr, if_id_pc4, if_id_valid : IF/ID register outputs
//   branch_target, jump_target          : targets derived from IF/ID
// -----------------------------------------------------------------------------
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  branch_mux,
  input  logic        if_flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  pcsel_e      pc_sel;

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc + PC_STEP;

  // Targets are resolved from what decode currently holds, not from pc.
  assign branch_target = if_id_pc4 + branch_offset(if_id_instr[15:0]);
  assign jump_target   = jump_addr(if_id_pc4, if_id_instr[25:0]);

  assign pc_sel = pcsel_e'(branch_mux);

  // Next-PC mux; the reserved select falls back to sequential.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PCSEL_SEQ:    next_pc = pc_plus4;
      PCSEL_BRANCH: next_pc = branch_target;
      PCSEL_JUMP:   next_pc = jump_target;
      PCSEL_RSVD:   next_pc = pc_plus4;
      default:      next_pc = pc_plus4;
    endcase
  end

  // PC register: stall holds it and masks any redirect request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (stall) begin
      pc <= pc;
    end else begin
      pc <= next_pc;
    end
  end

  assign imem_addr = pc;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (if_flush),
    .instr_in (imem_data),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scenarios followed by randomized control, checked against a
// behavioural model through an expected-state queue drained by a monitor.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  branch_mux;
  logic        if_flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  int checks;
  int failures;

  // Memory image: mode 0 -> word k = 0x1000 + k, mode 1 -> pseudo-random word.
  logic        mem_mode;
  logic        force_en;
  logic [31:0] force_word;
  logic [31:0] seed;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] bt;
    logic [31:0] jt;
  } exp_t;

  exp_t exp_q[$];

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_mux    (branch_mux),
    .if_flush      (if_flush),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic mode, input logic [31:0] s);
    if (mode == 1'b0) return 32'h0000_1000 + (addr >> 2);
    return (addr * 32'h9E37_79B1) ^ s ^ (addr >> 7);
  endfunction

  always_comb begin
    imem_data = force_en ? force_word : mem_word(imem_addr, mem_mode, seed);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Targets from the model's IF/ID contents using plain integer arithmetic.
  function automatic logic [31:0] model_bt();
    int off;
    off = $signed(m_instr[15:0]);
    return m_pc4 + 32'(off * 4);
  endfunction

  function automatic logic [31:0] model_jt();
    return (m_pc4 & 32'hF000_0000) + ((m_instr & 32'h03FF_FFFF) * 32'd4);
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.bt = model_bt(); e.jt = model_jt();
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_0000; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock edge of the fetch rules.
  task automatic model_step(input logic s, input logic [1:0] b, input logic f);
    logic [31:0] fetched;
    logic [31:0] seq;
    logic [31:0] npc;
    if (s) return;
    fetched = force_en ? force_word : mem_word(m_pc, mem_mode, seed);
    seq = m_pc + 32'd4;
    if (b == 2'd1)      npc = model_bt();
    else if (b == 2'd2) npc = model_jt();
    else                npc = seq;
    if (f) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = fetched; m_pc4 = seq; m_valid = 1'b1;
    end
    m_pc = npc;
  endtask

  // Drive controls, advance one edge, queue the expected post-edge state.
  task automatic do_cycle(input logic s, input logic [1:0] b, input logic f);
    stall = s; branch_mux = b; if_flush = f;
    #1;
    model_step(s, b, f);
    @(posedge clk);
    exp_q.push_back(model_snapshot());
    #1;
  endtask

  // Monitor: compares queued expectations against the DUT on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",            imem_addr,             e.pc);
        check("if_id_instr",   if_id_instr,           e.instr);
        check("if_id_pc4",     if_id_pc4,             e.pc4);
        check("if_id_valid",   {31'd0, if_id_valid},  {31'd0, e.valid});
        check("branch_target", branch_target,         e.bt);
        check("jump_target",   jump_target,           e.jt);
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; stall = 1'b0; branch_mux = 2'd0; if_flush = 1'b0;
    mem_mode = 1'b0; force_en = 1'b0; force_word = 32'h0; seed = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(model_snapshot());

    // Reset then three sequential fetches
    repeat (3) do_cycle(1'b0, 2'd0, 1'b0);
    check("t1_pc",    imem_addr,   32'h0000_000C);
    check("t1_pc4",   if_id_pc4,   32'h0000_000C);
    check("t1_instr", if_id_instr, 32'h0000_1002);
    check("t1_valid", {31'd0, if_id_valid}, 32'd1);

    // Taken branch, imm 3, pc4 0x10
    force_en = 1'b1; force_word = 32'h1000_0003;
    do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b0;
    check("t2_bt", branch_target, 32'h0000_001C);
    do_cycle(1'b0, 2'd1, 1'b1);
    check("t2_pc",    imem_addr,   32'h0000_001C);
    check("t2_instr", if_id_instr, 32'h0000_0000);
    check("t2_valid", {31'd0, if_id_valid}, 32'd0);

    // Negative immediate, then jump to 0x100
    force_en = 1'b1; force_word = 32'h1000_FFFE;
    do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b0;
    check("t3_bt_neg", branch_target, 32'h0000_0018);
    repeat (3) do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b1; force_word = 32'h0800_0040;
    do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b0;
    check("t3_pc4", if_id_pc4, 32'h0000_0030);
    do_cycle(1'b0, 2'd2, 1'b1);
    check("t3_pc",    imem_addr, 32'h0000_0100);
    check("t3_valid", {31'd0, if_id_valid}, 32'd0);

    // Stall priority at pc 0x14
    force_en = 1'b1; force_word = 32'h0800_0005;
    do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b0;
    do_cycle(1'b0, 2'd2, 1'b1);
    check("t4_pc_pre", imem_addr, 32'h0000_0014);
    do_cycle(1'b1, 2'd0, 1'b0);
    do_cycle(1'b1, 2'd1, 1'b1);
    check("t4_pc_hold",    imem_addr, 32'h0000_0014);
    check("t4_valid_hold", {31'd0, if_id_valid}, 32'd0);
    do_cycle(1'b0, 2'd0, 1'b0);
    check("t4_pc_release", imem_addr, 32'h0000_0018);

    // Branch to 0xFFFF_FFFC, then wrap via the reserved select
    force_en = 1'b1; force_word = 32'h1000_FFF8;
    do_cycle(1'b0, 2'd0, 1'b0);
    force_en = 1'b0;
    check("t5_bt", branch_target, 32'hFFFF_FFFC);
    do_cycle(1'b0, 2'd1, 1'b1);
    check("t5_pc_top", imem_addr, 32'hFFFF_FFFC);
    do_cycle(1'b0, 2'd3, 1'b0);
    check("t5_pc_wrap", imem_addr, 32'h0000_0000);
    check("t5_pc4",     if_id_pc4, 32'h0000_0000);

    // Asynchronous reset while pc = 0x40
    repeat (16) do_cycle(1'b0, 2'd0, 1'b0);
    check("t6_pc_pre", imem_addr, 32'h0000_0040);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_pc_async",    imem_addr, 32'h0000_0000);
    check("t6_valid_async", {31'd0, if_id_valid}, 32'd0);
    check("t6_instr_async", if_id_instr, 32'h0000_0000);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    do_cycle(1'b0, 2'd0, 1'b0);
    check("t6_first_pc4", if_id_pc4, 32'h0000_0004);

    // Randomized control against random memory
    mem_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
      end
      do_cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register consumed by decode and `pipecontrol`. It computes branch and jump targets from the IF/ID contents. It redirects the PC on the decode stage's `BranchMux` select, inserts a bubble on `IfFlush`, and freezes on a hazard-unit stall.

## Interface

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `stall`: input, 1 bit. From the hazard unit; holds the PC and IF/ID.
- `branch_mux`: input, 2 bits. PC source from decode control:
  - 0: sequential
  - 1: branch
  - 2: jump
  - 3: reserved, treated as 0
- `if_flush`: input, 1 bit. From decode control; loads a bubble into IF/ID.
- `imem_addr`: output, 32 bits. Equals the current PC (combinational from the PC register).
- `imem_data`: input, 32 bits. Instruction at `imem_addr`, combinational read.
- `if_id_instr`: output, 32 bits. Registered instruction for decode.
- `if_id_pc4`: output, 32 bits. Registered PC+4 of `if_id_instr`.
- `if_id_valid`: output, 1 bit. 0 for bubbles and after reset.
- `branch_target`: output, 32 bits. `if_id_pc4 + {sext(if_id_instr[15:0]), 2'b00}`.
- `jump_target`: output, 32 bits. `{if_id_pc4[31:28], if_id_instr[25:0], 2'b00}`.

## Operation

- State:
  - `pc` (32 bits).
  - IF/ID register: `instr`, `pc4`, `valid`.
- `pc_plus4 = pc + 32'd4`, modulo 2^32. `32'hFFFF_FFFC` wraps to 0.
- Branch-target arithmetic is 32-bit modulo 2^32:
  - sign-extend bit 15 of the immediate, then shift left 2;
  - overflow is discarded.
- Next-PC mux:
  - `branch_mux` 1 selects `branch_target`.
  - `branch_mux` 2 selects `jump_target`.
  - 0 and 3 select `pc_plus4`.
- Per-edge priority, highest first:
  1. `reset` (asynchronous):
     - `pc` = `RESET_PC`;
     - `instr` = 0, `pc4` = 0, `valid` = 0.
  2. `stall`: `pc` and the whole IF/ID register hold. `branch_mux` and `if_flush` are ignored that cycle; decode re-evaluates the held instruction on the next cycle.
  3. Otherwise `pc` takes next-PC, and IF/ID is written as follows:
     - If `if_flush`: IF/ID takes `instr` = 32'h0 (NOP, `sll $0,$0,0`), `pc4` = 0, `valid` = 0. The instruction fetched this cycle is discarded.
     - Else: IF/ID takes `instr` = `imem_data`, `pc4` = `pc_plus4`, `valid` = 1.
- `if_flush` with `branch_mux` 0 still flushes; the PC advances sequentially.
- `branch_mux` nonzero without `if_flush` redirects the PC without a bubble. This combination is legal but not produced by control.
- Low PC bits are not checked. Misaligned targets cannot arise, since both targets end in `2'b00`.

## Timing

- Redirect penalty is one cycle.
  - A branch or jump is resolved in ID in cycle N.
  - The target is fetched in cycle N+1.
  - It appears in IF/ID after the edge ending N+1.
- Fetch-to-decode latency is one cycle (one register stage).
- `branch_target` and `jump_target` are combinational from IF/ID and valid in the same cycle as `if_id_instr`.
- Reset mid-operation:
  - outputs go to their reset values immediately, without waiting for a clock edge;
  - the first fetch after deassertion is at `RESET_PC`.
- Stall may be held for any number of cycles with no state drift.

## Structure

- Shared package `pipe_pkg` holds:
  - PC-select encodings `PCSEL_SEQ` = 0, `PCSEL_BRANCH` = 1, `PCSEL_JUMP` = 2;
  - the `NOP_INSTR` constant;
  - the `RESET_PC` default.
  `pipecontrol` is updated to use the same encodings.
- Sub-module `if_id_reg` holds the IF/ID register with its reset, stall (hold) and flush (bubble) logic.
- The PC register, next-PC mux and target adders live in `fetch_stage`.

## Test plan

1. **Reset and sequential fetch.** Assert `reset`, release, then run 3 clocks with memory word k = `0x1000+k` → `pc` = `0xC`, `if_id_pc4` = `0xC`, `if_id_instr` = `0x1002`, `if_id_valid` = 1.
2. **Taken branch.** `if_id_instr` = `0x1000_0003` (beq, imm 3), `if_id_pc4` = `0x10`, with `branch_mux` = 1 and `if_flush` = 1 → `branch_target` = `0x1C`. Next cycle: `pc` = `0x1C`, `if_id_instr` = 0, `if_id_valid` = 0.
3. **Negative offset and jump.**
   - imm `0xFFFE` with `if_id_pc4` = `0x20` → `branch_target` = `0x18`.
   - `if_id_instr` = `0x0800_0040` with `if_id_pc4` = `0x30`, `branch_mux` = 2, `if_flush` = 1 → `pc` = `0x100` and a bubble in IF/ID.
4. **Stall priority.** Hold `stall` for 2 cycles at `pc` = `0x14`, including one cycle with `branch_mux` = 1 and `if_flush` = 1 → `pc`, `if_id_instr`, `if_id_pc4` and `if_id_valid` are unchanged. After release, the redirect takes effect only if control reasserts it.
5. **Wrap and reserved select.** `pc` = `0xFFFF_FFFC` with `branch_mux` = 3 → next `pc` = 0 and `if_id_pc4` = 0.
6. **Asynchronous reset mid-run.** Assert `reset` between clock edges while `pc` = `0x40` → `pc` = `RESET_PC` and `if_id_valid` = 0 before the next edge.
